ddr_burst_write_ctrl: RTL
=========================

Name: ddr_burst_write_ctrl

Overview:
- Sequences 128-bit words from the word FIFO (filled by the byte packer) into AXI4 INCR write bursts toward the DDR controller.
- Waits until a full burst of words is buffered, then issues the AW, W and B phases strictly in order.
- Advances a circular write pointer inside a fixed DDR region and reports sticky error and progress status.

Parameters:
- WORD_WIDTH, 128, data beat width in bits; must be a power of two, at least 8.
- ADDR_WIDTH, 32, AXI address width.
- BURST_LEN, 4, beats per burst, 1..16.
- CNT_WIDTH, 5, width of the word FIFO occupancy count.
- BASE_ADDR, 32'h0000_0000, region start; aligned to BURST_LEN*WORD_WIDTH/8.
- REGION_BYTES, 4096, region size; a multiple of the burst stride, and a power of two ≤4096 or a multiple of 4096.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new bursts to start.
- fifo_count  in  CNT_WIDTH  word FIFO occupancy.
- fifo_dout  in  WORD_WIDTH  word FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  word FIFO read strobe.
- m_awaddr  out  ADDR_WIDTH  write address.
- m_awlen  out  8  beats minus 1.
- m_awsize  out  3  log2(WORD_WIDTH/8).
- m_awburst  out  2  constant 2'b01 (INCR).
- m_awvalid  out  1; m_awready  in  1.
- m_wdata  out  WORD_WIDTH; m_wstrb  out  WORD_WIDTH/8, all ones.
- m_wlast  out  1; m_wvalid  out  1; m_wready  in  1.
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1.
- busy  out  1  state is not IDLE.
- wr_err  out  1  sticky; set by any m_bresp other than 2'b00.
- burst_count  out  16  completed bursts; wraps at 16'hFFFF to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all valid, ready and strobe outputs are 0; m_wdata is 0; wr_err is 0; burst_count is 0; the internal pointer is BASE_ADDR; state is IDLE. Assertion of rst_n mid-burst aborts the burst immediately. No recovery of the AXI transaction is attempted.
- IDLE: when enable=1 and fifo_count≥BURST_LEN:
  - load m_awaddr with the pointer;
  - set m_awlen = BURST_LEN-1;
  - assert m_awvalid next cycle;
  - go to ADDR.
- ADDR: hold m_awvalid and m_awaddr stable until m_awready. On the handshake cycle, drop m_awvalid, clear the beat counter, go to FETCH.
- FETCH: fifo_rd_en=1 for exactly one cycle, then go to LOAD.
- LOAD: capture fifo_dout into m_wdata; assert m_wvalid; m_wlast = (beat==BURST_LEN-1); go to DATA.
- DATA: hold m_wdata, m_wvalid and m_wlast stable until m_wready. On the handshake, drop m_wvalid and m_wlast, then:
  - if last beat, go to RESP;
  - otherwise increment beat and go to FETCH.
  - Throughput is therefore at most one beat per 3 cycles; this is accepted.
- RESP: m_bready=1. On m_bvalid:
  - set wr_err if m_bresp≠0 (the burst is not retried);
  - increment burst_count;
  - advance the pointer by BURST_LEN*WORD_WIDTH/8; if it reaches BASE_ADDR+REGION_BYTES, reload BASE_ADDR;
  - go to IDLE.
- enable deasserted mid-burst: the current burst completes and no new burst starts.
- fifo_count is sampled only in IDLE. A burst never reads more words than it has counted.
- The parameter constraints guarantee no burst crosses a 4KB boundary.
- Earliest restart: one cycle after the RESP exit.
- W is never presented before the AW handshake completes.

Optional Feature:
- Macro: DDR_BURST_FLUSH_EN.
- With the macro defined:
  - adds input flush_req (1 bit) and output flush_done (1-bit pulse).
  - In IDLE, when flush_req=1 and 0<fifo_count<BURST_LEN, issue a partial burst with m_awlen = fifo_count-1. That count is latched in IDLE.
  - On the B handshake, the pointer still advances by the full burst stride to keep alignment.
  - flush_done pulses one cycle at that B handshake.
  - flush_req with fifo_count=0 pulses flush_done the next cycle with no AXI traffic.
  - A full-burst condition has priority over flush.
- Without the macro: the ports are absent and only full bursts are issued.

Test Plan:
- Reset, enable=1, fifo_count=4, slaves always ready, dout = 1,2,3,4 → one burst at awaddr 0x0, awlen 3, awsize 4, awburst 1. Beats 1..4 with wlast on beat 4 only; burst_count=1.
- fifo_count=3, enable=1 → no awvalid for 50 cycles. Raise count to 4 → burst starts within 2 cycles.
- REGION_BYTES=128: perform 3 bursts → addresses 0x00, 0x40, 0x00.
- m_wready held 0 for 10 cycles on beat 2 → m_wdata, m_wvalid and m_wlast stay stable, and fifo_rd_en stays 0 until the handshake.
- bresp=2'b10 on burst 1, 2'b00 on burst 2 → wr_err=1 and stays 1; burst_count=2.
- rst_n low during DATA state → all outputs at reset values immediately. Next burst uses awaddr=BASE_ADDR.

Source files
------------

// File: rtl/ddr_burst_write_ctrl.sv
// Drains buffered 128-bit words into AXI4 INCR write bursts inside a circular DDR region.
// Optional flush of partial bursts is enabled by defining DDR_BURST_FLUSH_EN.
module ddr_burst_write_ctrl #(
  parameter int                    WORD_WIDTH   = 128,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    BURST_LEN    = 4,
  parameter int                    CNT_WIDTH    = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter int                    REGION_BYTES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [CNT_WIDTH-1:0]    fifo_count,
  input  logic [WORD_WIDTH-1:0]   fifo_dout,
  output logic                    fifo_rd_en,
`ifdef DDR_BURST_FLUSH_EN
  input  logic                    flush_req,
  output logic                    flush_done,
`endif
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [WORD_WIDTH-1:0]   m_wdata,
  output logic [WORD_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    busy,
  output logic                    wr_err,
  output logic [15:0]             burst_count
);

  localparam int                    STRIDE     = BURST_LEN * WORD_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] REGION_END = BASE_ADDR + ADDR_WIDTH'(REGION_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_DATA  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH-1:0] ptr_inc_s;
  logic [ADDR_WIDTH-1:0] ptr_next_s;
  logic [3:0]            beat_r;
  logic                  full_s;
  logic                  last_beat_s;
`ifdef DDR_BURST_FLUSH_EN
  logic                  flush_r;
`endif

  assign ptr_inc_s   = ptr_r + ADDR_WIDTH'(STRIDE);
  assign ptr_next_s  = (ptr_inc_s == REGION_END) ? BASE_ADDR : ptr_inc_s;
  assign full_s      = (32'(fifo_count) >= 32'(BURST_LEN));
  // Compare against the issued length so partial bursts terminate correctly too.
  assign last_beat_s = (beat_r == m_awlen[3:0]);

  assign m_awsize  = 3'($clog2(WORD_WIDTH / 8));
  assign m_awburst = 2'b01;
  assign m_wstrb   = {(WORD_WIDTH/8){1'b1}};

  // Burst sequencer: AW, then one FETCH/LOAD/DATA round per beat, then B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ptr_r       <= BASE_ADDR;
      beat_r      <= 4'd0;
      fifo_rd_en  <= 1'b0;
      m_awaddr    <= BASE_ADDR;
      m_awlen     <= 8'd0;
      m_awvalid   <= 1'b0;
      m_wdata     <= {WORD_WIDTH{1'b0}};
      m_wlast     <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      busy        <= 1'b0;
      wr_err      <= 1'b0;
      burst_count <= 16'd0;
`ifdef DDR_BURST_FLUSH_EN
      flush_r     <= 1'b0;
      flush_done  <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
`ifdef DDR_BURST_FLUSH_EN
      flush_done <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (enable && full_s) begin
            m_awaddr  <= ptr_r;
            m_awlen   <= 8'(BURST_LEN - 1);
            m_awvalid <= 1'b1;
            busy      <= 1'b1;
            state_r   <= S_ADDR;
`ifdef DDR_BURST_FLUSH_EN
            flush_r   <= 1'b0;
          end else if (flush_req && (fifo_count == {CNT_WIDTH{1'b0}})) begin
            flush_done <= 1'b1;
          end else if (enable && flush_req) begin
            m_awaddr  <= ptr_r;
            m_awlen   <= 8'(fifo_count - CNT_WIDTH'(1));
            m_awvalid <= 1'b1;
            busy      <= 1'b1;
            flush_r   <= 1'b1;
            state_r   <= S_ADDR;
`endif
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (m_awready) begin
            m_awvalid  <= 1'b0;
            beat_r     <= 4'd0;
            fifo_rd_en <= 1'b1;
            state_r    <= S_FETCH;
          end else begin
            state_r <= S_ADDR;
          end
        end
        S_FETCH: begin
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          m_wdata  <= fifo_dout;
          m_wvalid <= 1'b1;
          m_wlast  <= last_beat_s;
          state_r  <= S_DATA;
        end
        S_DATA: begin
          if (m_wready) begin
            m_wvalid <= 1'b0;
            m_wlast  <= 1'b0;
            if (last_beat_s) begin
              m_bready <= 1'b1;
              state_r  <= S_RESP;
            end else begin
              beat_r     <= beat_r + 4'd1;
              fifo_rd_en <= 1'b1;
              state_r    <= S_FETCH;
            end
          end else begin
            state_r <= S_DATA;
          end
        end
        S_RESP: begin
          if (m_bvalid) begin
            m_bready    <= 1'b0;
            wr_err      <= wr_err | (m_bresp != 2'b00);
            burst_count <= burst_count + 16'd1;
            ptr_r       <= ptr_next_s;
            busy        <= 1'b0;
            state_r     <= S_IDLE;
`ifdef DDR_BURST_FLUSH_EN
            flush_done  <= flush_r;
            flush_r     <= 1'b0;
`endif
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          m_awvalid <= 1'b0;
          m_wvalid  <= 1'b0;
          m_wlast   <= 1'b0;
          m_bready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
